// File: rtl/hack_vga_line_fetcher.sv
// Hack screen line fetcher: pulls one 32-word row per visible line into a line
// buffer during horizontal blanking, then shifts it out as a centred 1-bit pixel.
module hack_vga_line_fetcher #(
    parameter int H_OFFSET   = 64,
    parameter int V_OFFSET   = 112,
    parameter int FETCH_LEAD = 128,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pix_stb,
    input  logic                  i_hs,
    input  logic                  i_vs,
    input  logic                  i_active,
    input  logic [9:0]            i_x,
    input  logic [9:0]            i_y,
    input  logic [9:0]            i_clks_before_active,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [15:0]           i_mem_data,
    output logic                  o_hs,
    output logic                  o_vs,
    output logic                  o_active,
    output logic                  o_pixel,
    output logic                  o_underrun
);

    typedef enum logic {IDLE, REQ} fetchState_t;

    fetchState_t           state_q, state_d;
    logic [4:0]            wordIdx_q, wordIdx_d;
    logic [5:0]            fetchCount_q, fetchCount_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           lineBuf_q [32];
    logic                  bufWe;

    logic                  hs_q, vs_q, active_q, pixel_q, underrun_q;
    logic                  underrunDone_q;

    logic                  rowValid;
    logic [7:0]            rowIdx;
    logic                  trigger;
    logic [ADDR_WIDTH-1:0] rowBase;
    logic                  inSpan;
    logic [8:0]            col;
    logic [15:0]           wordRd;
    logic                  wordFetched;
    logic                  imageHit;
    logic                  pixelD;
    logic                  underrunHit;

    assign rowValid = (i_y >= 10'(V_OFFSET)) && (i_y < 10'(V_OFFSET + 256));
    assign rowIdx   = 8'(i_y - 10'(V_OFFSET));
    assign trigger  = i_pix_stb && (i_clks_before_active == 10'(FETCH_LEAD)) && rowValid;
    assign rowBase  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({rowIdx, 5'b0});

    assign inSpan   = (i_x >= 10'(H_OFFSET)) && (i_x < 10'(H_OFFSET + 512));
    assign col      = 9'(i_x - 10'(H_OFFSET));

    // A new trigger always wins, restarting the fetch even mid-row.
    always_comb begin
        state_d      = state_q;
        wordIdx_d    = wordIdx_q;
        fetchCount_d = fetchCount_q;
        addr_d       = addr_q;
        bufWe        = 1'b0;
        if (trigger) begin
            state_d      = REQ;
            wordIdx_d    = 5'd0;
            fetchCount_d = 6'd0;
            addr_d       = rowBase;
        end else if (state_q == REQ && i_mem_ack) begin
            bufWe        = 1'b1;
            fetchCount_d = fetchCount_q + 6'd1;
            if (wordIdx_q == 5'd31) begin
                state_d = IDLE;
            end else begin
                wordIdx_d = wordIdx_q + 5'd1;
                addr_d    = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            wordIdx_q    <= 5'd0;
            fetchCount_q <= 6'd0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            wordIdx_q    <= wordIdx_d;
            fetchCount_q <= fetchCount_d;
            addr_q       <= addr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (bufWe && !i_rst) begin
            lineBuf_q[wordIdx_q] <= i_mem_data;
        end
    end

    // Word being written this cycle is forwarded so the pixel sees it at once.
    always_comb begin
        wordRd      = lineBuf_q[col[8:4]];
        wordFetched = ({1'b0, col[8:4]} < fetchCount_q);
        if (bufWe && (wordIdx_q == col[8:4])) begin
            wordRd      = i_mem_data;
            wordFetched = 1'b1;
        end
        imageHit    = i_active && inSpan && rowValid;
        pixelD      = imageHit && wordFetched && !wordRd[col[3:0]];
        underrunHit = imageHit && !wordFetched;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            active_q       <= 1'b0;
            pixel_q        <= 1'b0;
            underrun_q     <= 1'b0;
            underrunDone_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (trigger) begin
                underrunDone_q <= 1'b0;
            end
            if (i_pix_stb) begin
                hs_q     <= i_hs;
                vs_q     <= i_vs;
                active_q <= i_active;
                pixel_q  <= pixelD;
                if (underrunHit && !underrunDone_q) begin
                    underrun_q     <= 1'b1;
                    underrunDone_q <= 1'b1;
                end
            end
        end
    end

    assign o_mem_req  = (state_q == REQ);
    assign o_mem_addr = addr_q;
    assign o_hs       = hs_q;
    assign o_vs       = vs_q;
    assign o_active   = active_q;
    assign o_pixel    = pixel_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_hack_vga_line_fetcher.sv
// Bench for hack_vga_line_fetcher: a reactive memory plus a pixel/row model
// derived from screen geometry, checked scenario by scenario.
module tb_hack_vga_line_fetcher;

    localparam int H_OFF = 64;
    localparam int V_OFF = 112;
    localparam int LEAD  = 128;
    localparam int BIG   = 1 << 30;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pix_stb = 1'b0;
    logic        i_hs = 1'b1;
    logic        i_vs = 1'b1;
    logic        i_active = 1'b0;
    logic [9:0]  i_x = '0;
    logic [9:0]  i_y = '0;
    logic [9:0]  i_clks_before_active = '0;
    logic        o_mem_req;
    logic [12:0] o_mem_addr;
    logic        i_mem_ack = 1'b0;
    logic [15:0] i_mem_data = '0;
    logic        o_hs, o_vs, o_active, o_pixel, o_underrun;

    logic [15:0] mem [8192];
    int          checks = 0;
    int          errors = 0;
    int          ackCount = 0;
    int          ackBase = 0;
    int          ackBudget = BIG;
    int          ackDelay = 0;
    int          waitCnt = 0;
    int          reqStarts = 0;
    int          holdViolations = 0;
    int          underrunPulses = 0;
    bit          forceAck = 1'b0;
    bit          uflag = 1'b0;
    logic [12:0] ackAddrQ [$];
    logic        prevReq = 1'b0;
    logic        prevAck = 1'b0;
    logic [12:0] prevAddr = '0;
    logic        expPixel, expUnder, expHs, expVs, expActive;

    hack_vga_line_fetcher dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
        .i_hs(i_hs), .i_vs(i_vs), .i_active(i_active),
        .i_x(i_x), .i_y(i_y), .i_clks_before_active(i_clks_before_active),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
        .o_hs(o_hs), .o_vs(o_vs), .o_active(o_active),
        .o_pixel(o_pixel), .o_underrun(o_underrun)
    );

    always #5 i_clk = ~i_clk;

    // Memory side: acks after ackDelay waits, limited by ackBudget.
    always @(negedge i_clk) begin
        if (forceAck) begin
            i_mem_ack  = 1'b1;
            i_mem_data = 16'($urandom);
        end else if (o_mem_req && ackBudget > 0) begin
            if (waitCnt >= ackDelay) begin
                i_mem_ack  = 1'b1;
                i_mem_data = mem[o_mem_addr];
                waitCnt    = 0;
                ackBudget--;
            end else begin
                i_mem_ack = 1'b0;
                waitCnt++;
            end
        end else begin
            i_mem_ack = 1'b0;
            waitCnt   = 0;
        end
    end

    always @(posedge i_clk) begin
        if (o_mem_req && i_mem_ack && !i_rst) begin
            ackCount++;
            ackAddrQ.push_back(o_mem_addr);
        end
        if (o_mem_req && !prevReq) reqStarts++;
        if (prevReq && o_mem_req && !prevAck && o_mem_addr != prevAddr) holdViolations++;
        if (o_underrun) underrunPulses++;
        prevReq  = o_mem_req;
        prevAck  = i_mem_ack;
        prevAddr = o_mem_addr;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // One pixel strobe; afterwards exp* hold what the screen rules predict.
    task automatic doStrobe(input int x, input int y, input bit act, input int cba);
        int fetchedNow;
        int w;
        int b;
        bit rowOk;
        @(negedge i_clk);
        i_pix_stb = 1'b1;
        i_x = 10'(x);
        i_y = 10'(y);
        i_active = act;
        i_clks_before_active = 10'(cba);
        i_hs = 1'($urandom);
        i_vs = 1'($urandom);
        expHs = i_hs;
        expVs = i_vs;
        expActive = act;
        @(posedge i_clk);
        #1;
        i_pix_stb = 1'b0;
        rowOk = (y >= V_OFF) && (y < V_OFF + 256);
        fetchedNow = ackCount - ackBase;
        expPixel = 1'b0;
        expUnder = 1'b0;
        if (act && rowOk && x >= H_OFF && x < H_OFF + 512) begin
            w = (x - H_OFF) / 16;
            b = (x - H_OFF) % 16;
            if (w < fetchedNow) expPixel = !mem[(y - V_OFF) * 32 + w][b];
            else if (!uflag) begin
                expUnder = 1'b1;
                uflag = 1'b1;
            end
        end
        if (cba == LEAD && rowOk) begin
            ackBase = ackCount;
            uflag = 1'b0;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b expected 0", o_mem_req); end
        checks++; if (o_mem_addr !== 13'd0) begin errors++; $display("[TB] FAIL reset_addr got %0d expected 0", o_mem_addr); end
        checks++; if (o_pixel !== 1'b0) begin errors++; $display("[TB] FAIL reset_pixel got %b expected 0", o_pixel); end
        checks++; if (o_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active got %b expected 0", o_active); end
        checks++; if (o_hs !== 1'b1) begin errors++; $display("[TB] FAIL reset_hs got %b expected 1", o_hs); end
        checks++; if (o_vs !== 1'b1) begin errors++; $display("[TB] FAIL reset_vs got %b expected 1", o_vs); end
        checks++; if (o_underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun got %b expected 0", o_underrun); end
        i_rst = 1'b0;
        ackBase = ackCount;
        uflag = 1'b0;
        idle(2);
    endtask

    task automatic test_full_frame();
        logic [12:0] modelQ [$];
        int startsBefore;
        int y;
        int bad;
        for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
        ackDelay = 0;
        ackBudget = BIG;
        ackAddrQ.delete();
        startsBefore = reqStarts;
        for (int v = 0; v < 525; v++) begin
            y = (v + 1) % 525;
            if (y > 479) y = 479;
            if (y >= V_OFF && y < V_OFF + 256)
                for (int k = 0; k < 32; k++) modelQ.push_back(13'((y - V_OFF) * 32 + k));
            doStrobe(672, y, 1'b0, LEAD);
            idle(35);
        end
        checks++;
        if (reqStarts - startsBefore != 256) begin
            errors++; $display("[TB] FAIL frame_fetches got %0d expected 256", reqStarts - startsBefore);
        end
        checks++;
        if (ackAddrQ.size() != modelQ.size()) begin
            errors++; $display("[TB] FAIL frame_words got %0d expected %0d", ackAddrQ.size(), modelQ.size());
        end else begin
            bad = -1;
            for (int i = 0; i < modelQ.size(); i++) if (bad < 0 && ackAddrQ[i] !== modelQ[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++; $display("[TB] FAIL frame_addr_seq idx %0d got %0d expected %0d", bad, ackAddrQ[bad], modelQ[bad]);
            end
            checks++; if (ackAddrQ[0] !== 13'd0) begin errors++; $display("[TB] FAIL frame_first_addr got %0d expected 0", ackAddrQ[0]); end
            checks++; if (ackAddrQ[8191] !== 13'd8191) begin errors++; $display("[TB] FAIL frame_last_addr got %0d expected 8191", ackAddrQ[8191]); end
        end
        checks++; if (o_mem_req !== 1'b0) begin errors++; $display("[TB] FAIL frame_end_req got %b expected 0", o_mem_req); end
    endtask

    // Whole line: optional blanking (with fetch trigger), then 640 active strobes.
    task automatic test_line(input string name, input int y, input int div, input bit blank,
                             input int releaseX, input int delay);
        int startsBefore;
        int underBefore;
        int holdBefore;
        int expUnderCount;
        int x;
        int cba;
        bit act;
        ackDelay = delay;
        ackBudget = (releaseX >= 0) ? 0 : BIG;
        startsBefore = reqStarts;
        underBefore = underrunPulses;
        holdBefore = holdViolations;
        expUnderCount = 0;
        for (int i = (blank ? 0 : 160); i < 800; i++) begin
            x = (640 + i) % 800;
            act = (x < 640);
            cba = act ? 0 : 800 - x;
            if (x == releaseX) ackBudget = BIG;
            doStrobe(x, y, act, cba);
            if (expUnder) expUnderCount++;
            checks++;
            if (o_pixel !== expPixel) begin
                errors++; $display("[TB] FAIL %s pixel x=%0d y=%0d got %b expected %b", name, x, y, o_pixel, expPixel);
            end
            checks++;
            if ({o_hs, o_vs, o_active, o_underrun} !== {expHs, expVs, expActive, expUnder}) begin
                errors++; $display("[TB] FAIL %s hs/vs/active/underrun x=%0d got %b expected %b", name, x,
                                   {o_hs, o_vs, o_active, o_underrun}, {expHs, expVs, expActive, expUnder});
            end
            if (div > 1) begin
                idle(div - 1);
                checks++;
                if ({o_pixel, o_underrun} !== {expPixel, 1'b0}) begin
                    errors++; $display("[TB] FAIL %s hold x=%0d got %b expected %b", name, x, {o_pixel, o_underrun}, {expPixel, 1'b0});
                end
            end
        end
        idle(4);
        ackBudget = BIG;
        checks++;
        if (underrunPulses - underBefore != expUnderCount) begin
            errors++; $display("[TB] FAIL %s underrun_pulses got %0d expected %0d", name, underrunPulses - underBefore, expUnderCount);
        end
        checks++;
        if (reqStarts - startsBefore != ((blank && y >= V_OFF && y < V_OFF + 256) ? 1 : 0)) begin
            errors++; $display("[TB] FAIL %s fetch_starts got %0d", name, reqStarts - startsBefore);
        end
        checks++;
        if (holdViolations != holdBefore) begin
            errors++; $display("[TB] FAIL %s addr_hold violations got %0d expected 0", name, holdViolations - holdBefore);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int startsBefore;
        ackDelay = 0;
        ackBudget = 10;
        doStrobe(672, 150, 1'b0, LEAD);
        idle(20);
        checks++; if (o_mem_req !== 1'b1) begin errors++; $display("[TB] FAIL midfetch_req got %b expected 1", o_mem_req); end
        checks++;
        if (o_mem_addr !== 13'((150 - V_OFF) * 32 + 10)) begin
            errors++; $display("[TB] FAIL midfetch_addr got %0d expected %0d", o_mem_addr, (150 - V_OFF) * 32 + 10);
        end
        checks++; if (ackCount - ackBase != 10) begin errors++; $display("[TB] FAIL midfetch_acks got %0d expected 10", ackCount - ackBase); end
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        checks++; if (o_mem_req !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req got %b expected 0", o_mem_req); end
        checks++; if (o_mem_addr !== 13'd0) begin errors++; $display("[TB] FAIL midreset_addr got %0d expected 0", o_mem_addr); end
        i_rst = 1'b0;
        ackBase = ackCount;
        uflag = 1'b0;
        startsBefore = reqStarts;
        forceAck = 1'b1;
        ackBudget = BIG;
        @(posedge i_clk);
        #1;
        forceAck = 1'b0;
        idle(30);
        checks++; if (o_mem_req !== 1'b0) begin errors++; $display("[TB] FAIL postreset_req got %b expected 0", o_mem_req); end
        checks++; if (reqStarts != startsBefore) begin errors++; $display("[TB] FAIL postreset_starts got %0d expected 0", reqStarts - startsBefore); end
        test_line("post_reset_no_trigger", 150, 1, 1'b0, -1, 0);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog timeout got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0001;
        test_line("row0", 112, 1, 1'b1, -1, 0);
        test_line("delayed_ack", 200, 4, 1'b1, -1, 5);
        test_line("underrun", 300, 1, 1'b1, 200, 0);
        test_line("vblank", 479, 1, 1'b1, -1, 0);
        test_line("above_window", 111, 1, 1'b1, -1, 0);
        test_line("below_window", 368, 1, 1'b1, -1, 0);
        test_line("random_row", 112 + int'($urandom_range(0, 255)), 2, 1'b1, -1, int'($urandom_range(0, 3)));
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_vga_line_fetcher.md
# hack_vga_line_fetcher

Pixel-fetch stage directly downstream of the 640x480 video timing generator. Each visible screen line, it reads one 512-pixel row of the Hack screen memory (32 × 16-bit words) into a line buffer. The fetch runs during horizontal blanking over a req/ack memory port. During active video it serialises the buffered bits to a 1-bit pixel, with the 512x256 image centred in the 640x480 raster. It also delays sync/active by one pixel strobe so they stay aligned with the registered pixel.

## Interface

Parameters:
- H_OFFSET, 64: first active x of the Hack image.
- V_OFFSET, 112: first active y of the Hack image.
- FETCH_LEAD, 128: value of i_clks_before_active that triggers the line fetch.
- BASE_ADDR, 0: memory word address of Hack screen row 0, word 0.
- ADDR_WIDTH, 13: memory address width.

Ports:
- i_clk  in  1  system clock; all state updates on posedge.
- i_rst  in  1  reset i_rst, synchronous, active-high.
- i_pix_stb  in  1  pixel strobe; timing inputs are sampled and the pixel pipeline advances only when high.
- i_hs, i_vs  in  1 each  sync from the timing generator (active low).
- i_active  in  1  active-pixel flag from the timing generator.
- i_x, i_y  in  10 each  current pixel position from the timing generator.
- i_clks_before_active  in  10  pixel strobes remaining until the line's active region.
- o_mem_req  out  1  read request.
- o_mem_addr  out  ADDR_WIDTH  word address; stable while o_mem_req is high.
- i_mem_ack  in  1  read accepted; i_mem_data is valid in the same cycle.
- i_mem_data  in  16  memory word.
- o_hs, o_vs, o_active  out  1 each  inputs delayed by one strobe.
- o_pixel  out  1  1 = white, aligned with o_active.
- o_underrun  out  1  one i_clk pulse when a needed word was not yet fetched.

## Operation

- Line window: row r = i_y − V_OFFSET. Row r is valid when i_y ≥ V_OFFSET and i_y < V_OFFSET+256. i_y clamps at 479 during vertical blank, which is outside the window.
- Fetch trigger: i_pix_stb is high, i_clks_before_active == FETCH_LEAD, and row r is valid.
- Fetch FSM states:
  - IDLE: o_mem_req = 0. On trigger, latch r, clear word index k = 0 and the fetched count, then go to REQ.
  - REQ: o_mem_req = 1 and o_mem_addr = BASE_ADDR + r*32 + k (wraps modulo 2^ADDR_WIDTH). On i_mem_ack, write i_mem_data to buf[k] and increment the fetched count. If k == 31, go to IDLE; otherwise k++ and stay in REQ, so back-to-back acks give 1 word/cycle.
  - A trigger arriving while in REQ restarts the fetch at k = 0 for the new row.
  - i_mem_ack while in IDLE is ignored.
- Pixel mapping: column c = i_x − H_OFFSET, with the image spanning i_x in [H_OFFSET, H_OFFSET+511]. Word w = c>>4, bit b = c[3:0], LSB = leftmost pixel. A Hack bit of 1 means black, so o_pixel = ~buf[w][b].
- Pixel is 0 (black border) when any of these hold: i_active = 0, i_x is outside the image span, row r is invalid, or word w has not yet been fetched (w ≥ fetched count).
- Underrun: o_underrun pulses once per line, at the first strobe where a pixel is forced to 0 only because w ≥ fetched count.
- Reset:
  - FSM returns to IDLE and the fetched count to 0.
  - Outputs: o_mem_req = 0, o_mem_addr = 0, o_pixel = 0, o_active = 0, o_hs = 1, o_vs = 1, o_underrun = 0.
  - Buffer contents are don't-care.
  - Reset mid-fetch drops o_mem_req on the next edge; a late ack is ignored.

## Timing

- Pixel path latency: 1 strobe. o_hs, o_vs, o_active and o_pixel register together when i_pix_stb is high, and hold between strobes.
- Fetch logic runs every i_clk; memory latency is unbounded.
- Budget: with FETCH_LEAD = 128, 32 words must be acked within 128 + H_OFFSET = 192 strobes of the trigger to avoid underrun.
- o_mem_addr and o_mem_req change only on an ack edge, a trigger, or reset.
- Buffer write and pixel read of the same word in the same cycle returns the new data (write-first).

## Test plan

- Reset, then full frame with ack tied high and memory holding word value = address: exactly 256 fetches per frame. First fetch addr = 0 at i_y = 112; last fetch addr = 8160–8191 at i_y = 367.
- Row 0, word 0 = 0x0001: at i_y = 112, o_pixel = 0 for i_x = 64 and 1 for i_x = 65..79, each one strobe late. i_x 0..63 and 576..639 give 0.
- Ack delayed 5 cycles per word: o_mem_addr is held during the wait and advances by 1 per ack. No underrun at pix_stb = i_clk/4.
- Ack withheld until after active starts: o_underrun pulses once and pixels are 0 for unfetched words. Remaining words fill in mid-line and appear as soon as fetched.
- i_rst asserted with k = 10 in REQ: next edge gives o_mem_req = 0; a subsequent ack leaves the buffer and count unchanged; after release, no output until the next trigger.
- i_y = 479 (vblank) and i_y = 111 / 368: no fetch is triggered and o_pixel = 0.
